io_port_bridge: RTL and testbench

External-side partner of the CPU's programmed I/O ports: it consumes words the CPU writes to its output port and produces words the CPU reads from its input port. Outbound words go into a small FIFO that an off-chip consumer drains with a valid/ready handshake. Inbound words from an off-chip producer are captured into a single holding register with a data-available flag for the CPU. The block sits beside `system`, between its `outport_data`/`inport_data` pins and board-level I/O.

---
 rtl/io_port_bridge.sv | 109 ++++++++++
 tb/tb_io_port_bridge.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/io_port_bridge.sv
// CPU programmed-I/O bridge: outbound words go through a circular FIFO with a valid/ready drain; inbound words land in a one-word holding register.
// Define IO_BRIDGE_OVERFLOW_EN to build the sticky out_overflow flag; otherwise it is tied low.
module io_port_bridge #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_outport_write,
  input  logic [WIDTH-1:0]         in_outport_data,
  output logic [WIDTH-1:0]         out_tx_data,
  output logic                     out_tx_valid,
  input  logic                     in_tx_ready,
  output logic [$clog2(DEPTH):0]   out_tx_count,
  output logic                     out_tx_full,
  output logic                     out_overflow,
  input  logic [WIDTH-1:0]         in_rx_data,
  input  logic                     in_rx_valid,
  output logic                     out_rx_ready,
  output logic [WIDTH-1:0]         out_inport_data,
  output logic                     out_rx_avail,
  input  logic                     in_inport_read
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RX_EMPTY, RX_FULL} rx_state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop;
  rx_state_t        rx_state, rx_state_nxt;
  logic             rx_capture;

  assign out_tx_full  = (count == CW'(DEPTH));
  assign out_tx_valid = (count != '0);
  assign out_tx_count = count;
  assign out_tx_data  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a write to a full FIFO is still accepted.
  assign pop  = out_tx_valid && in_tx_ready;
  assign push = in_outport_write && (!out_tx_full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_outport_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef IO_BRIDGE_OVERFLOW_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_overflow <= 1'b0;
    end else if (in_outport_write && !push) begin
      out_overflow <= 1'b1;
    end
  end
`else
  assign out_overflow = 1'b0;
`endif

  // Inbound holding register: one word in flight, ready is a pure state decode.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_capture   = 1'b0;
    case (rx_state)
      RX_EMPTY: begin
        if (in_rx_valid) begin
          rx_capture   = 1'b1;
          rx_state_nxt = RX_FULL;
        end
      end
      RX_FULL: begin
        if (in_inport_read) rx_state_nxt = RX_EMPTY;
      end
      default: rx_state_nxt = RX_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state        <= RX_EMPTY;
      out_inport_data <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      if (rx_capture) out_inport_data <= in_rx_data;
    end
  end

  assign out_rx_ready = (rx_state == RX_EMPTY);
  assign out_rx_avail = (rx_state == RX_FULL);

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed bench for io_port_bridge (DEPTH=4, WIDTH=32): vector table plus wrap and async-reset sequences.
module tb_io_port_bridge;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
`ifdef IO_BRIDGE_OVERFLOW_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_outport_write;
  logic [WIDTH-1:0] in_outport_data;
  logic [WIDTH-1:0] out_tx_data;
  logic             out_tx_valid;
  logic             in_tx_ready;
  logic [2:0]       out_tx_count;
  logic             out_tx_full;
  logic             out_overflow;
  logic [WIDTH-1:0] in_rx_data;
  logic             in_rx_valid;
  logic             out_rx_ready;
  logic [WIDTH-1:0] out_inport_data;
  logic             out_rx_avail;
  logic             in_inport_read;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  io_port_bridge #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_outport_write (in_outport_write),
    .in_outport_data  (in_outport_data),
    .out_tx_data      (out_tx_data),
    .out_tx_valid     (out_tx_valid),
    .in_tx_ready      (in_tx_ready),
    .out_tx_count     (out_tx_count),
    .out_tx_full      (out_tx_full),
    .out_overflow     (out_overflow),
    .in_rx_data       (in_rx_data),
    .in_rx_valid      (in_rx_valid),
    .out_rx_ready     (out_rx_ready),
    .out_inport_data  (out_inport_data),
    .out_rx_avail     (out_rx_avail),
    .in_inport_read   (in_inport_read)
  );

  typedef struct {
    logic        wr;
    logic [31:0] wdata;
    logic        txr;
    logic        rxv;
    logic [31:0] rxd;
    logic        rd;
    int          cnt;
    logic        vld;
    logic [31:0] head;
    logic        full;
    logic        ovf;
    logic        rdy;
    logic        avail;
    logic [31:0] idata;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(logic wr, logic [31:0] wdata, logic txr, logic rxv,
                              logic [31:0] rxd, logic rd, int cnt, logic vld,
                              logic [31:0] head, logic full, logic ovf, logic rdy,
                              logic avail, logic [31:0] idata);
    vec_t v;
    v.wr = wr; v.wdata = wdata; v.txr = txr; v.rxv = rxv; v.rxd = rxd; v.rd = rd;
    v.cnt = cnt; v.vld = vld; v.head = head; v.full = full; v.ovf = ovf;
    v.rdy = rdy; v.avail = avail; v.idata = idata;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " count"},  64'(out_tx_count), 64'd0);
    check({tag, " valid"},  64'(out_tx_valid), 64'd0);
    check({tag, " full"},   64'(out_tx_full), 64'd0);
    check({tag, " ovf"},    64'(out_overflow), 64'd0);
    check({tag, " rdy"},    64'(out_rx_ready), 64'd1);
    check({tag, " avail"},  64'(out_rx_avail), 64'd0);
    check({tag, " idata"},  64'(out_inport_data), 64'd0);
  endtask

  initial begin
    logic [31:0] q[$];
    int          guard;

    // cnt/vld/head/full/ovf-if-enabled/rdy/avail/idata after the edge of each vector
    tbl[0]  = mk(1, 32'h11, 0, 0, 0, 0, 1, 1, 32'h11, 0, 0, 1, 0, 0);
    tbl[1]  = mk(1, 32'h22, 0, 0, 0, 0, 2, 1, 32'h11, 0, 0, 1, 0, 0);
    tbl[2]  = mk(1, 32'h33, 0, 0, 0, 0, 3, 1, 32'h11, 0, 0, 1, 0, 0);
    tbl[3]  = mk(0, 0,      1, 0, 0, 0, 2, 1, 32'h22, 0, 0, 1, 0, 0);
    tbl[4]  = mk(0, 0,      1, 0, 0, 0, 1, 1, 32'h33, 0, 0, 1, 0, 0);
    tbl[5]  = mk(0, 0,      1, 0, 0, 0, 0, 0, 32'h0,  0, 0, 1, 0, 0);
    tbl[6]  = mk(1, 32'hA0, 0, 0, 0, 0, 1, 1, 32'hA0, 0, 0, 1, 0, 0);
    tbl[7]  = mk(1, 32'hA1, 0, 0, 0, 0, 2, 1, 32'hA0, 0, 0, 1, 0, 0);
    tbl[8]  = mk(1, 32'hA2, 0, 0, 0, 0, 3, 1, 32'hA0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(1, 32'hA3, 0, 0, 0, 0, 4, 1, 32'hA0, 1, 0, 1, 0, 0);
    tbl[10] = mk(1, 32'hB5, 1, 0, 0, 0, 4, 1, 32'hA1, 1, 0, 1, 0, 0);
    tbl[11] = mk(1, 32'hA4, 0, 0, 0, 0, 4, 1, 32'hA1, 1, 1, 1, 0, 0);
    tbl[12] = mk(0, 0,      1, 0, 0, 0, 3, 1, 32'hA2, 0, 1, 1, 0, 0);
    tbl[13] = mk(0, 0,      1, 0, 0, 0, 2, 1, 32'hA3, 0, 1, 1, 0, 0);
    tbl[14] = mk(0, 0,      1, 0, 0, 0, 1, 1, 32'hB5, 0, 1, 1, 0, 0);
    tbl[15] = mk(0, 0,      1, 0, 0, 0, 0, 0, 32'h0,  0, 1, 1, 0, 0);
    tbl[16] = mk(0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 1, 32'hDEADBEEF);
    tbl[17] = mk(0, 0, 0, 1, 32'h12345678, 0, 0, 0, 0, 0, 1, 0, 1, 32'hDEADBEEF);
    tbl[18] = mk(0, 0, 0, 1, 32'h12345678, 1, 0, 0, 0, 0, 1, 1, 0, 32'hDEADBEEF);
    tbl[19] = mk(0, 0, 0, 1, 32'h12345678, 0, 0, 0, 0, 0, 1, 0, 1, 32'h12345678);
    tbl[20] = mk(0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 1, 1, 0, 32'h12345678);
    tbl[21] = mk(0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 1, 1, 0, 32'h12345678);

    reset = 1'b0;
    in_outport_write = 0; in_outport_data = '0; in_tx_ready = 0;
    in_rx_data = '0; in_rx_valid = 0; in_inport_read = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("idle");

    for (int i = 0; i < NV; i++) begin
      in_outport_write = tbl[i].wr;
      in_outport_data  = tbl[i].wdata;
      in_tx_ready      = tbl[i].txr;
      in_rx_valid      = tbl[i].rxv;
      in_rx_data       = tbl[i].rxd;
      in_inport_read   = tbl[i].rd;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d count", i), 64'(out_tx_count), 64'(tbl[i].cnt));
      check($sformatf("v%0d valid", i), 64'(out_tx_valid), 64'(tbl[i].vld));
      if (tbl[i].vld) check($sformatf("v%0d head", i), 64'(out_tx_data), 64'(tbl[i].head));
      check($sformatf("v%0d full", i),  64'(out_tx_full), 64'(tbl[i].full));
      check($sformatf("v%0d ovf", i),   64'(out_overflow), 64'(tbl[i].ovf & OVF));
      check($sformatf("v%0d rdy", i),   64'(out_rx_ready), 64'(tbl[i].rdy));
      check($sformatf("v%0d avail", i), 64'(out_rx_avail), 64'(tbl[i].avail));
      check($sformatf("v%0d idata", i), 64'(out_inport_data), 64'(tbl[i].idata));
    end
    in_outport_write = 0; in_tx_ready = 0; in_rx_valid = 0; in_inport_read = 0;

    // Wrap: 10 words through the circular buffer, popping while pushing.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_outport_write = 1;
      in_outport_data  = 32'hC0 + 32'(i);
      in_tx_ready      = (q.size() > 0);
      check($sformatf("wrap%0d count", i), 64'(out_tx_count), 64'(q.size()));
      if (q.size() > 0) check($sformatf("wrap%0d head", i), 64'(out_tx_data), 64'(q[0]));
      @(posedge clk);
      if (q.size() > 0) void'(q.pop_front());
      q.push_back(32'hC0 + 32'(i));
    end
    @(negedge clk);
    in_outport_write = 0;
    in_tx_ready      = 1;
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      check("drain valid", 64'(out_tx_valid), 64'd1);
      check("drain head", 64'(out_tx_data), 64'(q[0]));
      @(posedge clk);
      void'(q.pop_front());
      @(negedge clk);
      guard++;
    end
    check("drain done", 64'(out_tx_valid), 64'd0);
    in_tx_ready = 0;

    // Async reset with two words buffered and an inbound word pending.
    in_outport_write = 1; in_outport_data = 32'hE1;
    in_rx_valid = 1; in_rx_data = 32'hCAFEF00D;
    @(negedge clk);
    in_outport_data = 32'hE2; in_rx_valid = 0;
    @(negedge clk);
    in_outport_write = 0;
    check("pre-rst count", 64'(out_tx_count), 64'd2);
    check("pre-rst avail", 64'(out_rx_avail), 64'd1);
    check("pre-rst idata", 64'(out_inport_data), 64'hCAFEF00D);
    #2 reset = 1'b0;
    #1 check_reset_state("async");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
